// File: rtl/matmul_seq.sv
// Sequencer for an N x N x N matrix multiply: A/B read addresses, MAC strobes, C write strobes.
// Optional macro MATMUL_SEQ_START_EDGE_EN: treat start as a level and trigger on its rising edge.
module matmul_seq #(
  parameter int N  = 4,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [2*AW-1:0] a_addr,
  output logic [2*AW-1:0] b_addr,
  output logic            addr_vld,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            c_we,
  output logic [2*AW-1:0] c_addr,
  output logic            busy,
  output logic            done
);

  localparam int CW = 2 * AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_i, r_j, r_k;
  logic            r_drain;
  logic            r_addr_vld, r_busy, r_done;
  logic [CW-1:0]   r_a_addr, r_b_addr;
  logic            r_mac_en, r_mac_clr, r_we_p1, r_c_we;
  logic [CW-1:0]   r_caddr_p1, r_c_addr;
  logic [AW-1:0]   w_i_nxt, w_j_nxt, w_k_nxt;
  logic            w_last_i, w_last_j, w_last_k;
  logic            w_trig;

  function automatic logic [CW-1:0] flat_idx(input logic [AW-1:0] row, input logic [AW-1:0] col);
    flat_idx = CW'(row) * CW'(N) + CW'(col);
  endfunction

`ifdef MATMUL_SEQ_START_EDGE_EN
  logic r_start_s1, r_start_s2;

  // Register the raw level and keep one previous sample for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
    end
  end

  assign w_trig = r_start_s1 & ~r_start_s2;
`else
  assign w_trig = start;
`endif

  assign w_last_i = (r_i == AW'(N - 1));
  assign w_last_j = (r_j == AW'(N - 1));
  assign w_last_k = (r_k == AW'(N - 1));

  // k is innermost, then j, then i.
  always_comb begin
    w_k_nxt = r_k + AW'(1);
    w_j_nxt = r_j;
    w_i_nxt = r_i;
    if (w_last_k) begin
      w_k_nxt = '0;
      if (w_last_j) begin
        w_j_nxt = '0;
        w_i_nxt = r_i + AW'(1);
      end else begin
        w_j_nxt = r_j + AW'(1);
      end
    end else begin
      w_j_nxt = r_j;
    end
  end

  // Control FSM; addresses are registered from the next loop indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_drain    <= 1'b0;
      r_addr_vld <= 1'b0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_trig) begin
            r_state    <= S_RUN;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_addr_vld <= 1'b1;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last_i && w_last_j && w_last_k) begin
            r_state    <= S_DRAIN;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_drain    <= 1'b0;
            r_addr_vld <= 1'b0;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
          end else begin
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_a_addr <= flat_idx(w_i_nxt, w_k_nxt);
            r_b_addr <= flat_idx(w_k_nxt, w_j_nxt);
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_addr_vld <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage strobe pipeline aligned to 1-cycle RAM read and MAC accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mac_en   <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_we_p1    <= 1'b0;
      r_caddr_p1 <= '0;
      r_c_we     <= 1'b0;
      r_c_addr   <= '0;
    end else begin
      r_mac_en   <= r_addr_vld;
      r_mac_clr  <= r_addr_vld & (r_k == '0);
      r_we_p1    <= r_addr_vld & w_last_k;
      r_caddr_p1 <= r_addr_vld ? flat_idx(r_i, r_j) : '0;
      r_c_we     <= r_we_p1;
      r_c_addr   <= r_caddr_p1;
    end
  end

  assign a_addr   = r_a_addr;
  assign b_addr   = r_b_addr;
  assign addr_vld = r_addr_vld;
  assign mac_en   = r_mac_en;
  assign mac_clr  = r_mac_clr;
  assign c_we     = r_c_we;
  assign c_addr   = r_c_addr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Sequencer for the matrix-multiplication datapath. It issues address streams for the A and B operand memories and the MAC control strobes (clear, enable). It also issues write strobes for the C result memory, so one start request produces the full N×N×N multiply. It sits between the start-request synchronizer/edge-detector stage and the operand RAMs / MAC unit.

## Interface
Parameters:
- N, 4: matrix dimension (square N×N); legal range 2..16.
- AW, $clog2(N): index width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request. With MATMUL_SEQ_START_EDGE_EN undefined, this is a one-cycle pulse. With the macro defined, it is a raw level; see Configuration.
- a_addr  out  2*AW  A read address, row-major, i*N+k.
- b_addr  out  2*AW  B read address, row-major, k*N+j.
- addr_vld  out  1  a_addr/b_addr valid this cycle.
- mac_en  out  1  MAC consumes read data this cycle (addr_vld delayed 1).
- mac_clr  out  1  with mac_en: load product instead of accumulate (k==0 term).
- c_we  out  1  write accumulator to C.
- c_addr  out  2*AW  C write address, i*N+j; valid with c_we.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - All outputs 0.
  - A trigger (start==1) loads i=j=k=0 and moves to RUN.
- RUN:
  - addr_vld=1 every cycle; addresses are formed from the current i,j,k.
  - k increments each cycle. On k==N-1, k wraps to 0 and j increments.
  - On j==N-1 with k==N-1, j wraps and i increments.
  - On i=j=k=N-1, the state moves to DRAIN.
  - Exactly N³ address cycles are issued, back to back with no bubbles.
- Pipeline stage 1 (one cycle behind the address):
  - mac_en = addr_vld delayed.
  - mac_clr = (k==0 && addr_vld) delayed.
- Pipeline stage 2 (one cycle behind stage 1):
  - c_we = (k==N-1 && addr_vld) delayed twice.
  - c_addr = (i*N+j) delayed twice.
- DRAIN: lasts 2 cycles, addr_vld=0, and lets stages 1 and 2 empty. Then the state moves to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- busy=1 in RUN and DRAIN only.
- start outside IDLE is ignored, neither queued nor restarting the run.
- Address arithmetic is unsigned. i*N+j uses constant N and fits 2*AW bits by construction.
- Reset mid-run:
  - Asynchronous clear of the state, counters and pipeline to IDLE/0.
  - No c_we is emitted after rst_n falls.
  - The run is abandoned; the C contents are undefined.

## Timing
- Reset value of every output: 0.
- Edge E0 samples a trigger in IDLE. Then:
  - Address for (0,0,0) appears after E0 (cycle 1).
  - Last address appears at cycle N³.
- mac_en is high for cycles 2..N³+1.
- First c_we is at cycle N+2 with c_addr=0. Later c_we pulses follow every N cycles.
- Last c_we is at cycle N³+2 with c_addr=N²-1.
- done=1 at cycle N³+3, and busy falls in the same cycle.
- The next trigger is accepted at cycle N³+4 at the earliest.
- Operand RAMs must have exactly 1-cycle read latency. The MAC registers its accumulator on mac_en, so the final sum is valid in the cycle c_we is asserted.

## Configuration
- MATMUL_SEQ_START_EDGE_EN defined:
  - start is a level input (e.g. a button) and is registered internally.
  - A trigger is an inactive→active transition: previous sample 0, current sample 1.
  - Holding start high yields exactly one run.
  - Adds 1 cycle latency: E0 becomes the edge after the one where the transition is seen.
- Undefined:
  - start is used directly as the trigger.
  - start held high retriggers on every visit to IDLE, i.e. runs repeat back to back with one IDLE cycle between them.

## Test plan
- Reset: rst_n=0 with random start → all outputs 0. Release, no start → outputs stay 0 for 100 cycles.
- N=4, single start pulse:
  - 64 consecutive addr_vld cycles.
  - a_addr sequence 0,1,2,3,0,1,2,3,… (×4, then 4..7); b_addr sequence 0,4,8,12,1,5,9,13,…
  - 16 c_we pulses at cycles 6,10,…,66 with c_addr 0..15.
  - done at cycle 67.
- N=4 full-system run: A=ramp 1..16, B=identity → C written equals A. Accumulator check via mac_clr on every 4th mac_en.
- start pulses at cycles 10 and 66 during the run → ignored. Exactly one done pulse and 16 c_we.
- rst_n asserted at cycle 30 of a run → all outputs 0 the same cycle. After release, a new start produces a complete, correct run.
- Edge-start behaviour:
  - With MATMUL_SEQ_START_EDGE_EN: start held high for 200 cycles → exactly one run, done at cycle 68.
  - Without the macro: start held high → back-to-back runs.
